// File: rtl/wb_cmd_master.sv
// Wishbone pipelined-mode master: one bus cycle per accepted command,
// one response per command, with a timeout against silent slaves.
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic [DATA_WIDTH-1:0]   cmd_data_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [1:0]              rsp_status_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    input  logic                    wb_stall_i
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic                  active;
    logic                  done;
    logic                  tmo;
    logic [1:0]            nxt_status;
    logic [DATA_WIDTH-1:0] nxt_data;

    assign cmd_ready_o = (state == IDLE);

    // Completion decode: err beats rty beats ack, and any completion beats timeout.
    always_comb begin
        active     = (state == STROBE) || (state == WAIT);
        done       = wb_ack_i || wb_err_i || wb_rty_i;
        tmo        = (TIMEOUT != 0) && (cnt == CNT_LAST);
        nxt_status = ST_TMO;
        nxt_data   = '0;
        if (wb_err_i) begin
            nxt_status = ST_ERR;
        end else if (wb_rty_i) begin
            nxt_status = ST_RTY;
        end else if (wb_ack_i) begin
            nxt_status = ST_OK;
            nxt_data   = wb_we_o ? '0 : wb_dat_i;
        end
    end

    // Command FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_status_o <= 2'b00;
        end else begin
            rsp_valid_o <= 1'b0;
            if (active) begin
                cnt <= cnt + 1'b1;
            end
            if (active && (done || tmo)) begin
                // Slaves drop stall with ack, so completion ends STROBE regardless of stall.
                wb_cyc_o     <= 1'b0;
                wb_stb_o     <= 1'b0;
                rsp_valid_o  <= 1'b1;
                rsp_data_o   <= nxt_data;
                rsp_status_o <= nxt_status;
                state        <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid_i) begin
                            wb_we_o  <= cmd_we_i;
                            wb_adr_o <= cmd_addr_i;
                            wb_sel_o <= cmd_sel_i;
                            wb_dat_o <= cmd_data_i;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            cnt      <= '0;
                            state    <= STROBE;
                        end
                    end
                    STROBE: begin
                        if (!wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= WAIT;
                        end
                    end
                    WAIT:    state <= WAIT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small scripted Wishbone slave.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_sel_i(cmd_sel), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave script: stall for sl_stall strobe cycles, then respond either in the
    // first unstalled strobe cycle (sl_lat=0) or in WAIT cycle number sl_lat.
    // sl_kind: 0 silent, 1 ack, 2 err, 3 rty, 4 err+ack.
    int          sl_stall = 0;
    int          sl_lat   = 0;
    int          sl_kind  = 0;
    logic [31:0] sl_dat   = '0;
    int          s_k = 0;
    int          w_k = 0;

    always @(negedge clk) begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0; wb_dat_i = '0;
        if (!wb_cyc) begin
            s_k = 0; w_k = 0;
        end else if (wb_stb) begin
            if (s_k < sl_stall) wb_stall = 1'b1;
            else if (sl_lat == 0) begin
                case (sl_kind)
                    1: begin wb_ack = 1'b1; wb_dat_i = sl_dat; end
                    2: wb_err = 1'b1;
                    3: wb_rty = 1'b1;
                    4: begin wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = sl_dat; end
                    default: ;
                endcase
            end
            s_k++;
        end else begin
            w_k++;
            if (w_k == sl_lat) begin
                case (sl_kind)
                    1: begin wb_ack = 1'b1; wb_dat_i = sl_dat; end
                    2: wb_err = 1'b1;
                    3: wb_rty = 1'b1;
                    4: begin wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = sl_dat; end
                    default: ;
                endcase
            end
        end
    end

    // Issue one command and observe it up to the response. lat counts falling
    // edges after the accepting edge (1 = first STROBE cycle).
    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output int n_stb, output int n_cyc,
                          output int lat, output logic [31:0] rd, output logic [1:0] st,
                          output logic stable);
        n_stb = 0; n_cyc = 0; lat = 0; rd = '0; st = '0; stable = 1'b1;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = adr; cmd_sel = sel; cmd_data = dat;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            if (i > 1) @(negedge clk);
            if (rsp_valid) begin
                lat = i; rd = rsp_data; st = rsp_status;
                if (wb_cyc || wb_stb) stable = 1'b0;
            end else begin
                if (wb_stb) n_stb++;
                if (wb_cyc) n_cyc++;
                if (cmd_ready || wb_adr !== adr || wb_dat_o !== dat || wb_we !== we || wb_sel !== sel)
                    stable = 1'b0;
            end
        end
        if (lat == 0) chk("rsp_within_bound", rsp_valid, 1);
    endtask

    int          n_stb, n_cyc, lat;
    logic [31:0] rd;
    logic [1:0]  st;
    logic        stable;

    initial begin
        #12;
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk); rst_n = 1'b1;

        // read, ack in first strobe cycle
        sl_stall = 0; sl_lat = 0; sl_kind = 1; sl_dat = 32'hDEADBEEF;
        do_cmd(1'b0, 32'h10, 4'hF, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("rd_fast_lat", lat, 2);
        chk("rd_fast_stb", n_stb, 1);
        chk("rd_fast_data", rd, 32'hDEADBEEF);
        chk("rd_fast_status", st, 0);
        chk("rd_fast_stable", stable, 1);
        @(negedge clk);
        chk("rsp_pulse_once", rsp_valid, 0);
        chk("rsp_data_hold", rsp_data, 32'hDEADBEEF);

        // write with 3 stall cycles
        sl_stall = 3; sl_lat = 0; sl_kind = 1; sl_dat = 32'hCAFEF00D;
        do_cmd(1'b1, 32'h20, 4'hF, 32'h12345678, n_stb, n_cyc, lat, rd, st, stable);
        chk("wr_stall_stb", n_stb, 4);
        chk("wr_stall_lat", lat, 5);
        chk("wr_stall_status", st, 0);
        chk("wr_stall_data", rd, 0);
        chk("wr_stall_stable", stable, 1);

        // read accepted immediately, ack 5 cycles into WAIT
        sl_stall = 0; sl_lat = 5; sl_kind = 1; sl_dat = 32'hA5A50F0F;
        do_cmd(1'b0, 32'h30, 4'h3, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("rd_wait_stb", n_stb, 1);
        chk("rd_wait_cyc", n_cyc, 6);
        chk("rd_wait_lat", lat, 7);
        chk("rd_wait_data", rd, 32'hA5A50F0F);

        // err and ack together
        sl_stall = 0; sl_lat = 0; sl_kind = 4; sl_dat = 32'h11111111;
        do_cmd(1'b0, 32'h44, 4'hF, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("err_ack_status", st, 1);
        chk("err_ack_data", rd, 0);
        @(negedge clk); chk("err_no_retry", wb_cyc, 0);
        @(negedge clk); chk("err_no_retry2", wb_cyc, 0);

        // rty alone, in WAIT
        sl_stall = 0; sl_lat = 2; sl_kind = 3;
        do_cmd(1'b0, 32'h48, 4'hF, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("rty_status", st, 2);
        chk("rty_lat", lat, 4);
        chk("rty_data", rd, 0);
        @(negedge clk); chk("rty_no_retry", wb_cyc, 0);

        // silent slave: timeout after 8 cycles
        sl_stall = 0; sl_lat = 0; sl_kind = 0;
        do_cmd(1'b0, 32'h50, 4'hF, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("tmo_status", st, 3);
        chk("tmo_lat", lat, 9);
        chk("tmo_cyc_cycles", n_cyc, 8);
        chk("tmo_cyc_low_in_resp", stable, 1);

        // reset while in WAIT
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h60; cmd_sel = 4'hF; cmd_data = '0;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("wait_cyc", wb_cyc, 1);
        chk("wait_stb", wb_stb, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", wb_cyc, 0);
        chk("async_rst_stb", wb_stb, 0);
        @(negedge clk);
        chk("rst_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_rsp2", rsp_valid, 0);
        chk("post_rst_ready", cmd_ready, 1);

        sl_stall = 0; sl_lat = 0; sl_kind = 1; sl_dat = 32'h0BADF00D;
        do_cmd(1'b0, 32'h70, 4'hF, 32'h0, n_stb, n_cyc, lat, rd, st, stable);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", rd, 32'h0BADF00D);
        chk("post_rst_status", st, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone pipelined-mode bus master: the initiator side of the slave interfaces the team's generated register/SRAM bridges expose.
- Accepts single read/write commands on a valid/ready port and runs one Wishbone cycle per command, honouring stall, ack, err and rty.
- Returns one response per command, carrying read data and a status code; a timeout guards against unresponsive slaves.
- Used by test infrastructure and by the soft-CPU-less control paths to access generated register maps and memories.

Parameters:
ADDR_WIDTH  32   width of wb_adr_o and cmd_addr_i (byte address)
DATA_WIDTH  32   data width; must be 8, 16, 32 or 64
TIMEOUT     255  cycles allowed from entering STROBE to ack/err/rty; 0 disables the timeout

Ports:
clk_i        in   1               clock
rst_n_i      in   1               asynchronous active-low reset
cmd_valid_i  in   1               command present
cmd_ready_o  out  1               command accepted when valid and ready are both high
cmd_we_i     in   1               1=write, 0=read
cmd_addr_i   in   ADDR_WIDTH      byte address
cmd_sel_i    in   DATA_WIDTH/8    byte enables
cmd_data_i   in   DATA_WIDTH      write data
rsp_valid_o  out  1               one-cycle response pulse
rsp_data_o   out  DATA_WIDTH      read data, valid with rsp_valid_o
rsp_status_o out  2               00 ok, 01 err, 10 retry, 11 timeout
wb_cyc_o     out  1               Wishbone cycle
wb_stb_o     out  1               Wishbone strobe
wb_we_o      out  1               write enable
wb_adr_o     out  ADDR_WIDTH      address
wb_sel_o     out  DATA_WIDTH/8    byte select
wb_dat_o     out  DATA_WIDTH      write data
wb_dat_i     in   DATA_WIDTH      read data
wb_ack_i     in   1               acknowledge
wb_err_i     in   1               error
wb_rty_i     in   1               retry
wb_stall_i   in   1               stall

Behaviour:
- Reset is asynchronous, active-low. While rst_n_i=0 every output register is 0: cyc, stb, we, adr, sel, dat_o, rsp_valid, rsp_data, rsp_status. State is IDLE and the timeout counter is 0.
- Reset asserted mid-transaction drops cyc_o/stb_o immediately, with no response. The command is lost.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready_o=1 only in IDLE; otherwise 0.
  - On valid&ready: latch we/addr/sel/data into the wb_* output registers, clear the counter, go to STROBE.
- STROBE:
  - cyc=1, stb=1, and address/data/we/sel are held stable.
  - Completion (ack, err or rty) in this cycle goes to RESP. Completion applies whatever the stall value, because the slaves drive stall=~ack&en.
  - Else if stall_i=0: the request is accepted; go to WAIT.
  - Else stay in STROBE.
- WAIT: cyc=1, stb=0. Completion goes to RESP.
- Completion priority when several are asserted together: err > rty > ack.
  - ack: status 00. rsp_data is wb_dat_i captured at the ack edge for reads, 0 for writes.
  - err: status 01. rty: status 10. In both cases rsp_data is 0.
- Timeout:
  - The counter increments every cycle in STROBE and WAIT.
  - When TIMEOUT≠0 and counter=TIMEOUT-1 with no completion, go to RESP with status 11 and rsp_data 0.
  - A completion in that same cycle wins over the timeout.
- RESP:
  - Entered on the clock edge; cyc=0, stb=0, rsp_valid_o=1 for exactly this one cycle.
  - Next state is IDLE. rsp_data/rsp_status hold until the next response.
- Ack latency: an ack in the first STROBE cycle gives rsp_valid 2 cycles after the accepting edge. The minimum command interval is 3 cycles.
- No auto-retry; the retry decision belongs to the command source.
- wb_* address/data/sel/we keep their last value while idle. Only cyc and stb are forced low.
- Stray ack/err/rty while in IDLE or RESP is ignored.

Test Plan:
- Read of 0x0000_0010, slave acks in the first STROBE cycle with dat=0xDEADBEEF and stall=~ack: one stb cycle; rsp_valid 2 cycles after accept; rsp_data 0xDEADBEEF; status 00.
- Write of 0x12345678, sel=0xF, slave holds stall 3 cycles then acks: stb held 4 cycles with adr/dat stable; cmd_ready low throughout; status 00; rsp_data 0.
- Read where stall=0 at the first cycle and ack arrives 5 cycles later: stb is high for 1 cycle only; cyc stays high in WAIT; rsp_data captured at ack.
- err and ack asserted together: status 01. rty alone: status 10. No retry issued in either case.
- TIMEOUT=8 with the slave never responding: rsp_valid with status 11 exactly 8 cycles after entering STROBE; cyc low in RESP.
- rst_n_i asserted in WAIT: cyc/stb drop within the same cycle with no clock; no rsp_valid; after release, cmd_ready=1 and a new read completes normally.
